gobou_ctrl_mac: RTL and testbench
=================================

GOBOU_CTRL_MAC -- requirements
Module: gobou_ctrl_mac

Interface
REQ-001 Parameter D_MAC, default 3: latency in cycles from an accepted input word to its accumulated result at the MAC output; legal range 2..8.
REQ-002 Parameter LWIDTH, default 12: width of the layer size inputs and internal counters.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_ctrl, ctrl_bus.slave: start (layer begin pulse), valid (one input word present), stop (abort pulse).
REQ-006 Port n_in, input, LWIDTH: input words per output neuron; sampled when start is accepted.
REQ-007 Port n_out, input, LWIDTH: output neurons per layer; sampled when start is accepted.
REQ-008 Port out_ctrl, ctrl_bus.master: start, valid and stop toward the bias stage.
REQ-009 Port mac_en, output, 1: accumulate the current product.
REQ-010 Port mac_clr, output, 1: load the product in place of the accumulator sum (first word of a neuron).
REQ-011 Port busy, output, 1: high while the FSM is in RUN.

Function
REQ-012 FSM states SHALL be IDLE and RUN.
REQ-013 IDLE->RUN on in_ctrl.start when sampled n_in != 0 and n_out != 0; both values SHALL be latched and both counters cleared.
REQ-014 In IDLE, start with n_in == 0 or n_out == 0 SHALL be ignored: no state change and no output pulses.
REQ-015 In IDLE, in_ctrl.valid and in_ctrl.stop SHALL be ignored.
REQ-016 In RUN, each valid cycle accepts one word; word counter wcnt SHALL increment and wrap to 0 after n_in-1, and neuron counter ncnt SHALL increment at each wrap.
REQ-017 The word accepted with wcnt == n_in-1 and ncnt == n_out-1 is the final word; RUN->IDLE SHALL occur on the following edge.
REQ-018 In RUN, in_ctrl.start SHALL be ignored.
REQ-019 In RUN, in_ctrl.stop SHALL abort: RUN->IDLE on the next edge, counters cleared, and any valid in the same cycle not accepted.
REQ-020 If stop and the final word coincide, the abort SHALL take priority: no out_ctrl.valid for that word, and out_ctrl.stop as in REQ-025.
REQ-021 mac_en SHALL be high exactly one cycle after each accepted word; mac_clr SHALL be high with it when that word had wcnt == 0.
REQ-022 out_ctrl.start SHALL pulse D_MAC cycles after the accepted start.
REQ-023 out_ctrl.valid SHALL pulse D_MAC cycles after each accepted word with wcnt == n_in-1.
REQ-024 out_ctrl.stop SHALL pulse in the same cycle as the out_ctrl.valid of the final word.
REQ-025 An aborted run SHALL emit out_ctrl.stop D_MAC cycles after the stop cycle.
REQ-026 Pulses already in the delay line when an abort occurs SHALL still be delivered.
REQ-027 Counters SHALL be LWIDTH bits, and the full range n_in = n_out = 2^LWIDTH-1 SHALL work without overflow.
REQ-028 Back-to-back layers SHALL be supported: a start the cycle after RUN->IDLE SHALL be accepted.

Reset
REQ-029 While rst is high: state IDLE, counters 0, delay line cleared, and out_ctrl.start/valid/stop, mac_en, mac_clr and busy all 0.
REQ-030 Reset asserted mid-RUN SHALL discard all in-flight pulses with no out_ctrl.stop emitted; operation resumes from IDLE after release.

Verification
REQ-031 D_MAC=3, n_in=4, n_out=2, start at t=0, valid t=1..8 -> mac_clr at t=2,6; mac_en t=2..9; out_ctrl.start t=3; out_ctrl.valid t=7,11; out_ctrl.stop t=11; busy low from t=9.
REQ-032 n_in=1, n_out=3, valid t=1..3 -> mac_clr and mac_en t=2..4; out_ctrl.valid t=4..6; out_ctrl.stop t=6.
REQ-033 n_in=0 or n_out=0 at start -> busy stays 0; no out_ctrl pulses for 20 cycles.
REQ-034 n_in=4, n_out=2, stop at t=3 after valid t=1,2 -> busy low at t=4; out_ctrl.stop at t=6; no out_ctrl.valid.
REQ-035 Valid gapped every other cycle, n_in=3, n_out=1, words at t=1,3,5 -> out_ctrl.valid and out_ctrl.stop at t=8.
REQ-036 rst pulse at t=5 in REQ-031 stimulus -> all outputs 0 from t=5; no out_ctrl.valid or out_ctrl.stop afterward; a new start after release behaves as REQ-031.

Source files
------------

// File: rtl/gobou_ctrl_mac_if.sv
// ============================================================================
// Module   : ctrl_bus
// Brief    : Start/valid/stop handshake bundle between pipeline stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

`default_nettype wire

// File: rtl/gobou_ctrl_mac.sv
// ============================================================================
// Module   : gobou_ctrl_mac
// Brief    : MAC sequencer: counts words/neurons of a layer, drives the MAC
//            enables and forwards start/valid/stop to the bias stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gobou_ctrl_mac #(
    parameter int D_MAC  = 3,
    parameter int LWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_bus.slave            in_ctrl,
    input  logic [LWIDTH-1:0] n_in,
    input  logic [LWIDTH-1:0] n_out,
    ctrl_bus.master           out_ctrl,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_busy;

    logic [LWIDTH-1:0] r_nin;
    logic [LWIDTH-1:0] r_nout;
    logic [LWIDTH-1:0] r_wcnt;
    logic [LWIDTH-1:0] r_ncnt;
    logic [LWIDTH-1:0] w_nin_m1;
    logic [LWIDTH-1:0] w_nout_m1;

    logic              w_start_acc;
    logic              w_abort;
    logic              w_acc;
    logic              w_wlast;
    logic              w_nlast;
    logic              w_final;

    logic              r_mac_en;
    logic              r_mac_clr;
    logic [D_MAC-1:0]  r_dl_start;
    logic [D_MAC-1:0]  r_dl_valid;
    logic [D_MAC-1:0]  r_dl_stop;

    assign w_nin_m1    = r_nin - LWIDTH'(1);
    assign w_nout_m1   = r_nout - LWIDTH'(1);
    assign w_start_acc = (r_state == S_IDLE) && in_ctrl.start && (n_in != '0) && (n_out != '0);
    assign w_abort     = (r_state == S_RUN) && in_ctrl.stop;
    // A valid coinciding with stop is dropped so the abort wins over the final word.
    assign w_acc       = (r_state == S_RUN) && in_ctrl.valid && !in_ctrl.stop;
    assign w_wlast     = (r_wcnt == w_nin_m1);
    assign w_nlast     = (r_ncnt == w_nout_m1);
    assign w_final     = w_acc && w_wlast && w_nlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_abort || w_final) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nin  <= '0;
            r_nout <= '0;
            r_wcnt <= '0;
            r_ncnt <= '0;
        end else if (w_start_acc) begin
            r_nin  <= n_in;
            r_nout <= n_out;
            r_wcnt <= '0;
            r_ncnt <= '0;
        end else if (w_abort) begin
            r_wcnt <= '0;
            r_ncnt <= '0;
        end else if (w_acc) begin
            if (w_wlast) begin
                r_wcnt <= '0;
                r_ncnt <= w_nlast ? '0 : r_ncnt + LWIDTH'(1);
            end else begin
                r_wcnt <= r_wcnt + LWIDTH'(1);
            end
        end
    end

    // Delay lines align the forwarded control pulses with the MAC result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_en   <= 1'b0;
            r_mac_clr  <= 1'b0;
            r_dl_start <= '0;
            r_dl_valid <= '0;
            r_dl_stop  <= '0;
        end else begin
            r_mac_en   <= w_acc;
            r_mac_clr  <= w_acc && (r_wcnt == '0);
            r_dl_start <= {r_dl_start[D_MAC-2:0], w_start_acc};
            r_dl_valid <= {r_dl_valid[D_MAC-2:0], w_acc && w_wlast};
            r_dl_stop  <= {r_dl_stop[D_MAC-2:0], w_final || w_abort};
        end
    end

    assign out_ctrl.start = r_dl_start[D_MAC-1];
    assign out_ctrl.valid = r_dl_valid[D_MAC-1];
    assign out_ctrl.stop  = r_dl_stop[D_MAC-1];
    assign mac_en         = r_mac_en;
    assign mac_clr        = r_mac_clr;
    assign busy           = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_gobou_ctrl_mac.sv
// ============================================================================
// Module   : tb_gobou_ctrl_mac
// Brief    : Randomised and scenario stimulus against a word-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gobou_ctrl_mac;

    localparam int C_D     = 3;
    localparam int C_LW    = 4;
    localparam int C_EXP_N = 8192;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [C_LW-1:0] n_in = '0;
    logic [C_LW-1:0] n_out = '0;
    logic            mac_en;
    logic            mac_clr;
    logic            busy;

    ctrl_bus in_bus ();
    ctrl_bus out_bus ();

    gobou_ctrl_mac #(.D_MAC(C_D), .LWIDTH(C_LW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_ctrl  (in_bus),
        .n_in     (n_in),
        .n_out    (n_out),
        .out_ctrl (out_bus),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: expected output bits indexed by absolute cycle number.
    bit exp_ostart [C_EXP_N];
    bit exp_ovalid [C_EXP_N];
    bit exp_ostop  [C_EXP_N];
    bit exp_en     [C_EXP_N];
    bit exp_clr    [C_EXP_N];
    int cyc_no   = 0;
    bit m_run    = 0;
    int m_nin    = 0;
    int m_nout   = 0;
    int m_words  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_no, got, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit v, input bit sp, input bit r,
                       input int ni, input int no);
        bit was_run;
        int t;
        @(negedge clk);
        t               = cyc_no;
        rst             = r;
        in_bus.start    = st;
        in_bus.valid    = v;
        in_bus.stop     = sp;
        n_in            = C_LW'(ni);
        n_out           = C_LW'(no);
        #1;
        was_run = m_run;
        if (r) begin
            m_run = 0;
            for (int j = t; j < t + C_D + 2; j++) begin
                exp_ostart[j] = 0; exp_ovalid[j] = 0; exp_ostop[j] = 0;
                exp_en[j] = 0; exp_clr[j] = 0;
            end
        end else if (!m_run) begin
            if (st && ni != 0 && no != 0) begin
                m_run   = 1;
                m_nin   = ni;
                m_nout  = no;
                m_words = 0;
                exp_ostart[t + C_D] = 1;
            end
        end else if (sp) begin
            m_run = 0;
            exp_ostop[t + C_D] = 1;
        end else if (v) begin
            exp_en[t + 1]  = 1;
            exp_clr[t + 1] = (m_words % m_nin == 0);
            m_words++;
            if (m_words % m_nin == 0) exp_ovalid[t + C_D] = 1;
            if (m_words == m_nin * m_nout) begin
                exp_ostop[t + C_D] = 1;
                m_run = 0;
            end
        end
        chk("busy",      int'(busy),          int'(was_run && !r));
        chk("mac_en",    int'(mac_en),        int'(exp_en[t]));
        chk("mac_clr",   int'(mac_clr),       int'(exp_clr[t]));
        chk("out_start", int'(out_bus.start), int'(exp_ostart[t]));
        chk("out_valid", int'(out_bus.valid), int'(exp_ovalid[t]));
        chk("out_stop",  int'(out_bus.stop),  int'(exp_ostop[t]));
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_basic(input int rst_at);
        cyc(1, 0, 0, 0, 4, 2);
        for (int i = 1; i <= 8; i++) cyc(0, 1, 0, (i == rst_at), 4, 2);
        idle(6);
    endtask

    initial begin
        in_bus.start = 0;
        in_bus.valid = 0;
        in_bus.stop  = 0;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 1, 4, 2);
        idle(2);

        run_basic(0);
        cyc(1, 0, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 3);
        idle(6);

        cyc(1, 1, 0, 0, 0, 5);
        idle(20);
        cyc(1, 1, 1, 0, 5, 0);
        cyc(0, 1, 1, 0, 5, 5);
        idle(20);

        cyc(1, 0, 0, 0, 4, 2);
        cyc(0, 1, 0, 0, 4, 2);
        cyc(0, 1, 0, 0, 4, 2);
        cyc(0, 1, 1, 0, 4, 2);
        idle(6);

        cyc(1, 0, 0, 0, 3, 1);
        for (int i = 1; i <= 6; i++) cyc(0, (i % 2) == 1, 0, 0, 3, 1);
        idle(5);

        run_basic(5);
        run_basic(0);

        cyc(1, 0, 0, 0, 2, 1);
        cyc(0, 1, 0, 0, 2, 1);
        cyc(0, 1, 1, 0, 2, 1);
        idle(5);

        cyc(1, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 2, 2);
        for (int i = 0; i < 4; i++) cyc(i == 1, 1, 0, 0, 1, 1);
        idle(5);

        cyc(1, 0, 0, 0, 15, 15);
        for (int i = 0; i < 225; i++) cyc((i % 37) == 5, 1, 0, 0, 3, 3);
        idle(6);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7,
                $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
